// File: rtl/glitch_filter.sv
// Synchronises a raw level D and lets a change through to Q only after it has
// held for STABLE_CYCLES consecutive samples; RISE/FALL flag the Q transitions.
module glitch_filter #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic D,
   output logic Q,
   output logic RISE,
   output logic FALL,
   output logic BUSY
);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHECK_HI  = 2'd1,
      STABLE_HI = 2'd2,
      CHECK_LO  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   q_q, q_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   busy_q, busy_d;
   logic                   s;

   // Only the first stage sees D; everything else works from the resolved level.
   assign sync_d = {sync_q[SYNC_STAGES-2:0], D};
   assign s      = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         STABLE_LO: begin
            if (s) begin
               if (STABLE_CYCLES == 1) begin
                  state_d = STABLE_HI;
                  q_d     = 1'b1;
                  rise_d  = 1'b1;
               end else begin
                  state_d = CHECK_HI;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         CHECK_HI: begin
            if (!s) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
               q_d     = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STABLE_HI: begin
            if (!s) begin
               if (STABLE_CYCLES == 1) begin
                  state_d = STABLE_LO;
                  q_d     = 1'b0;
                  fall_d  = 1'b1;
               end else begin
                  state_d = CHECK_LO;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         CHECK_LO: begin
            if (s) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
               q_d     = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            q_d     = 1'b0;
         end
      endcase
      // BUSY reflects the counter value being written this cycle.
      busy_d = (cnt_d != '0);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_q  <= '0;
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         q_q     <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   assign Q    = q_q;
   assign RISE = rise_q;
   assign FALL = fall_q;
   assign BUSY = busy_q;

endmodule
